// File: rtl/px_stream_pkg.sv
// ---------------------------------------------------------------------------
// px_stream_pkg
// Shared constants for the raster pixel stream blocks.
//   DEF_*        : default pixel width and image geometry
//   CNT_W        : width of all column/line/centre counters
//   TAP_TL..BR   : row-major tap indices of a 3x3 window (4 is the centre)
//   win_state_e  : window generator state (RUN accepts pixels, FLUSH drains)
// ---------------------------------------------------------------------------
package px_stream_pkg;

    localparam int DEF_PX_SIZE      = 8;
    localparam int DEF_IMAGE_WIDTH  = 640;
    localparam int DEF_IMAGE_HEIGHT = 480;

    localparam int CNT_W = 12;

    localparam int TAP_TL = 0;
    localparam int TAP_TM = 1;
    localparam int TAP_TR = 2;
    localparam int TAP_ML = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_MR = 5;
    localparam int TAP_BL = 6;
    localparam int TAP_BM = 7;
    localparam int TAP_BR = 8;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } win_state_e;

endpackage

// File: rtl/px_line_buffer.sv
// ---------------------------------------------------------------------------
// px_line_buffer
// One image line of storage: simple dual-port RAM, registered read.
// A read and a write to the same address on one edge return the old data.
//   clk     : clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write column
//   wr_data : pixel to store
//   rd_addr : read column (data appears after the next rising edge)
//   rd_data : registered read data
// Contents are never reset.
// ---------------------------------------------------------------------------
module px_line_buffer
    import px_stream_pkg::*;
#(
    parameter  int DEPTH = DEF_IMAGE_WIDTH,
    parameter  int WIDTH = DEF_PX_SIZE,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/px_window_3x3.sv
// ---------------------------------------------------------------------------
// px_window_3x3
// Receives a raster pixel stream and emits one 3x3 neighbourhood per image
// pixel. Two chained line buffers hold lines y-1 and y-2; two column
// registers hold the previous two columns. After the last pixel of a frame
// a FLUSH phase of IMAGE_WIDTH+1 cycles drains the remaining centres.
//   clk, resetn       : clock (rising edge), asynchronous active-low reset
//   input_data        : incoming pixel
//   input_data_valid  : pixel strobe (ignored and flagged during FLUSH)
//   win_data          : 9 taps, tap k at bits [(k+1)*PX_SIZE-1 : k*PX_SIZE]
//   win_valid         : one-cycle strobe per window
//   win_x, win_y      : centre coordinate
//   win_border        : centre lies on the image edge
//   frame_done        : high with the last window of a frame
//   overrun           : sticky, pixel arrived during FLUSH
// ---------------------------------------------------------------------------
module px_window_3x3
    import px_stream_pkg::*;
#(
    parameter int PX_SIZE      = DEF_PX_SIZE,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PX_SIZE-1:0]   input_data,
    input  logic                 input_data_valid,
    output logic [9*PX_SIZE-1:0] win_data,
    output logic                 win_valid,
    output logic [CNT_W-1:0]     win_x,
    output logic [CNT_W-1:0]     win_y,
    output logic                 win_border,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam int AW = $clog2(IMAGE_WIDTH);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(IMAGE_WIDTH);

    win_state_e         state;
    logic [CNT_W-1:0]   in_col, in_line, flush_cnt, cen_x, cen_y;
    logic               flushing, accept, past_head, emit, step;
    logic [AW-1:0]      rd_addr;
    logic [PX_SIZE-1:0] lb1_q, lb2_q;
    logic [PX_SIZE-1:0] col_mid_p0  [3];
    logic [PX_SIZE-1:0] col_left_p1 [3];
    logic [PX_SIZE-1:0] taps        [9];

    assign flushing  = (state == ST_FLUSH);
    assign accept    = input_data_valid && !flushing;
    // Linear index n >= W+1, expressed on the column/line counters.
    assign past_head = (in_line >= 12'd2) || ((in_line == 12'd1) && (in_col != '0));
    assign emit      = (accept && past_head) || flushing;
    assign step      = accept || flushing;

    // The RAM read is registered, so address the column that the *next*
    // step will consume; its data is then ready on the same edge.
    always_comb begin
        rd_addr = in_col[AW-1:0];
        if (flushing) begin
            rd_addr = (flush_cnt >= X_LAST) ? '0 : AW'(flush_cnt + 1'b1);
        end else if (accept) begin
            rd_addr = (in_col == X_LAST) ? '0 : AW'(in_col + 1'b1);
        end
    end

    px_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PX_SIZE)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (in_col[AW-1:0]),
        .wr_data (input_data),
        .rd_addr (rd_addr),
        .rd_data (lb1_q)
    );

    px_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PX_SIZE)) u_lb2 (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (in_col[AW-1:0]),
        .wr_data (lb1_q),
        .rd_addr (rd_addr),
        .rd_data (lb2_q)
    );

    // Stage p0/p1: the two columns left of the incoming one (rows y-2, y-1, y).
    always_ff @(posedge clk) begin
        if (step) begin
            col_left_p1   <= col_mid_p0;
            col_mid_p0[0] <= lb2_q;
            col_mid_p0[1] <= lb1_q;
            col_mid_p0[2] <= input_data;
        end
    end

    // Incoming column is the right edge of the window; out-of-image taps
    // (including wrapped columns from the previous line) are zeroed.
    always_comb begin
        taps[TAP_TL] = col_left_p1[0];
        taps[TAP_TM] = col_mid_p0[0];
        taps[TAP_TR] = lb2_q;
        taps[TAP_ML] = col_left_p1[1];
        taps[TAP_C]  = col_mid_p0[1];
        taps[TAP_MR] = lb1_q;
        taps[TAP_BL] = col_left_p1[2];
        taps[TAP_BM] = col_mid_p0[2];
        taps[TAP_BR] = input_data;
        if (cen_x == '0) begin
            taps[TAP_TL] = '0; taps[TAP_ML] = '0; taps[TAP_BL] = '0;
        end
        if (cen_x == X_LAST) begin
            taps[TAP_TR] = '0; taps[TAP_MR] = '0; taps[TAP_BR] = '0;
        end
        if (cen_y == '0) begin
            taps[TAP_TL] = '0; taps[TAP_TM] = '0; taps[TAP_TR] = '0;
        end
        if (cen_y == Y_LAST) begin
            taps[TAP_BL] = '0; taps[TAP_BM] = '0; taps[TAP_BR] = '0;
        end
    end

    // Output stage: registered window, centre counters and frame FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_RUN;
            in_col     <= '0;
            in_line    <= '0;
            flush_cnt  <= '0;
            cen_x      <= '0;
            cen_y      <= '0;
            win_data   <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            win_border <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && (cen_x == X_LAST) && (cen_y == Y_LAST);
            if (emit) begin
                for (int k = 0; k < 9; k++) begin
                    win_data[k*PX_SIZE +: PX_SIZE] <= taps[k];
                end
                win_x      <= cen_x;
                win_y      <= cen_y;
                win_border <= (cen_x == '0) || (cen_x == X_LAST) ||
                              (cen_y == '0) || (cen_y == Y_LAST);
                if (cen_x == X_LAST) begin
                    cen_x <= '0;
                    cen_y <= (cen_y == Y_LAST) ? '0 : cen_y + 1'b1;
                end else begin
                    cen_x <= cen_x + 1'b1;
                end
            end

            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (in_col == X_LAST) begin
                            in_col <= '0;
                            if (in_line == Y_LAST) begin
                                in_line <= '0;
                                state   <= ST_FLUSH;
                            end else begin
                                in_line <= in_line + 1'b1;
                            end
                        end else begin
                            in_col <= in_col + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (input_data_valid) begin
                        overrun <= 1'b1;
                    end
                    if (flush_cnt == F_LAST) begin
                        flush_cnt <= '0;
                        state     <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_px_window_3x3.sv
// ---------------------------------------------------------------------------
// tb_px_window_3x3
// Scoreboard bench for px_window_3x3 at W=8, H=6. Each frame's expected
// windows are computed from the whole image array and queued when the frame
// is issued; a negedge monitor pops one entry per win_valid.
// ---------------------------------------------------------------------------
module tb_px_window_3x3;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int NPX = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  input_data = '0;
    logic        input_data_valid = 1'b0;
    logic [71:0] win_data;
    logic        win_valid;
    logic [11:0] win_x, win_y;
    logic        win_border, frame_done, overrun;

    px_window_3x3 #(.PX_SIZE(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .input_data       (input_data),
        .input_data_valid (input_data_valid),
        .win_data         (win_data),
        .win_valid        (win_valid),
        .win_x            (win_x),
        .win_y            (win_y),
        .win_border       (win_border),
        .frame_done       (frame_done),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] data;
        int          x;
        int          y;
        logic        border;
        logic        fdone;
    } win_t;

    win_t        sb[$];
    win_t        mon_e;
    logic [7:0]  img [NPX];
    logic [71:0] got [NPX];
    int          checks = 0;
    int          errors = 0;
    int          win_cnt = 0;
    int          fd_cnt = 0;
    bit          cur_idle = 1'b0;
    bit          last_idle = 1'b0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference window: neighbourhood of (x,y) straight from the image array.
    function automatic logic [71:0] ref_win(int x, int y);
        logic [71:0] r;
        r = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int xx, yy, k;
                xx = x + dx;
                yy = y + dy;
                k  = (dy + 1) * 3 + (dx + 1);
                if (xx >= 0 && xx < W && yy >= 0 && yy < H)
                    r[k*8 +: 8] = img[yy*W + xx];
            end
        end
        return r;
    endfunction

    task automatic fill_img(bit rnd);
        win_t e;
        for (int i = 0; i < NPX; i++) img[i] = rnd ? 8'($urandom) : 8'(i);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.data   = ref_win(x, y);
                e.x      = x;
                e.y      = y;
                e.border = (x == 0) || (x == W-1) || (y == 0) || (y == H-1);
                e.fdone  = (x == W-1) && (y == H-1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(logic [7:0] v);
        input_data       = v;
        input_data_valid = 1'b1;
        cur_idle         = 1'b0;
        tick();
        input_data_valid = 1'b0;
        input_data       = 8'($urandom);
    endtask

    task automatic idle_cycles(int n, bit run_idle);
        input_data_valid = 1'b0;
        cur_idle         = run_idle;
        repeat (n) begin
            input_data = 8'($urandom);
            tick();
        end
        cur_idle = 1'b0;
    endtask

    // Sends img[0..stop_at-1] (whole frame when stop_at < 0) with random gaps.
    task automatic drive_frame(int gap_pct, int stop_at);
        for (int i = 0; i < NPX; i++) begin
            for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
                idle_cycles(1, 1'b1);
            if (i == stop_at) return;
            send_px(img[i]);
        end
    endtask

    // Continuous index-valued frame with explicit first-window latency checks.
    task automatic run_index_frame(string tag);
        for (int i = 0; i < NPX; i++) begin
            send_px(img[i]);
            if (i == 8) check({tag, "_no_win_before_px9"}, win_valid, 1'b0);
            if (i == 9) begin
                check({tag, "_first_valid"}, win_valid, 1'b1);
                check({tag, "_first_xy_border"}, {win_x, win_y, win_border}, {12'd0, 12'd0, 1'b1});
            end
        end
    endtask

    task automatic finish_frame(string tag, int w0, int f0, int nwin, int nfd);
        idle_cycles(W + 1, 1'b0);
        tick();
        check({tag, "_win_count"}, win_cnt - w0, nwin);
        check({tag, "_frame_done_count"}, fd_cnt - f0, nfd);
        check({tag, "_scoreboard_drained"}, sb.size(), 0);
    endtask

    always @(posedge clk) last_idle = cur_idle;

    always @(negedge clk) begin
        if (resetn && win_valid) begin
            win_cnt++;
            if (frame_done) fd_cnt++;
            if (win_x < W && win_y < H) got[win_y*W + win_x] = win_data;
            check("valid_after_idle_run_cycle", last_idle, 1'b0);
            check("expected_window_available", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("window", {win_data, win_x, win_y, win_border, frame_done},
                      {mon_e.data, 12'(mon_e.x), 12'(mon_e.y), mon_e.border, mon_e.fdone});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int w0, f0;
        logic [71:0] exp_first, exp_mid;
        exp_first = {8'd9, 8'd8, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_mid   = {8'd28, 8'd27, 8'd26, 8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10};

        #3;
        check("reset_outputs", {win_valid, win_data, win_x, win_y, win_border, frame_done, overrun}, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        tick();

        // Continuous index frame.
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b0);
        run_index_frame("cont");
        finish_frame("cont", w0, f0, NPX, 1);
        check("cont_first_taps", got[0], exp_first);
        check("cont_interior_3_2_taps", got[2*W + 3], exp_mid);

        // Same image with ~50% input gaps.
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b0);
        drive_frame(50, -1);
        finish_frame("gaps", w0, f0, NPX, 1);
        check("gaps_interior_3_2_taps", got[2*W + 3], exp_mid);

        // Random pixel values with gaps.
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b1);
        drive_frame(30, -1);
        finish_frame("rand", w0, f0, NPX, 1);
        check("rand_no_overrun", overrun, 1'b0);

        // Pixel during FLUSH: dropped, flags overrun, next frame unaffected.
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b1);
        drive_frame(20, -1);
        idle_cycles(3, 1'b0);
        send_px(8'hAA);
        idle_cycles(W + 1 - 4, 1'b0);
        check("overrun_set", overrun, 1'b1);
        fill_img(1'b1);
        drive_frame(0, -1);
        finish_frame("overrun", w0, f0, 2*NPX, 2);
        check("overrun_sticky", overrun, 1'b1);

        // Asynchronous reset mid-clock while pixel 20 is presented.
        fill_img(1'b0);
        drive_frame(0, 20);
        input_data       = img[20];
        input_data_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {win_valid, win_data, win_x, win_y, win_border, frame_done, overrun}, '0);
        sb.delete();
        input_data_valid = 1'b0;
        tick();
        tick();
        #3;
        resetn = 1'b1;
        tick();
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b0);
        run_index_frame("after_reset");
        finish_frame("after_reset", w0, f0, NPX, 1);
        check("after_reset_first_taps", got[0], exp_first);

        // Two frames back to back with the minimum W+1 idle gap.
        w0 = win_cnt; f0 = fd_cnt;
        fill_img(1'b1);
        drive_frame(0, -1);
        idle_cycles(W + 1, 1'b0);
        fill_img(1'b1);
        drive_frame(0, -1);
        finish_frame("b2b", w0, f0, 2*NPX, 2);
        check("b2b_no_overrun", overrun, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
